// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT datapath defaults, lane index constants and width helper.
package ntt_pkg;
    localparam int DATA_W_DEF = 14;
    localparam int CNT_W_DEF  = 16;
    localparam int LANE_U0 = 0;
    localparam int LANE_V0 = 1;
    localparam int LANE_U1 = 2;
    localparam int LANE_V1 = 3;

    function automatic int clog2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/dff.sv
// dff: W-bit register cell with asynchronous active-low reset.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else      q <= d;
endmodule

// File: rtl/xbar_route.sv
// xbar_route: combinational source-to-lane priority router with collision detect.
module xbar_route import ntt_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_CH = 4,
    localparam int SEL_W = clog2(NUM_CH)
) (
    input  logic [NUM_CH*SEL_W-1:0]  sel,
    input  logic [NUM_CH-1:0]        src_en,
    input  logic [NUM_CH*DATA_W-1:0] q,
    output logic [NUM_CH*DATA_W-1:0] lane,
    output logic [NUM_CH-1:0]        lane_hit,
    output logic                     conflict
);
    // ascending scan: later (higher-index) sources overwrite, giving them priority
    always_comb begin
        lane     = '0;
        lane_hit = '0;
        conflict = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_en[i]) begin
                if (lane_hit[sel[i*SEL_W +: SEL_W]]) conflict = 1'b1;
                lane_hit[sel[i*SEL_W +: SEL_W]] = 1'b1;
                lane[int'(sel[i*SEL_W +: SEL_W])*DATA_W +: DATA_W] = q[i*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: rtl/bf_in_xbar.sv
// bf_in_xbar: bank-to-butterfly input crossbar with select alignment, optional
// output register and routing-conflict bookkeeping.
module bf_in_xbar import ntt_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_CH   = 4,
    parameter int PIPE_OUT = 1,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int SEL_W   = clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NUM_CH*SEL_W-1:0]  sel,
    input  logic [NUM_CH-1:0]        src_en,
    input  logic [NUM_CH*DATA_W-1:0] q,
    input  logic                     clr_err,
    output logic [NUM_CH*DATA_W-1:0] lane,
    output logic [NUM_CH-1:0]        lane_hit,
    output logic                     out_valid,
    output logic                     conflict,
    output logic                     conflict_sticky,
    output logic [CNT_W-1:0]         conflict_cnt
);
    logic                     v1;
    logic [NUM_CH*SEL_W-1:0]  sel1;
    logic [NUM_CH-1:0]        en1;
    logic [NUM_CH*DATA_W-1:0] r_lane;
    logic [NUM_CH-1:0]        r_hit;
    logic                     r_cf;
    logic                     evt;

    // enables are zeroed for idle cycles so a stale select cannot drive a lane
    dff #(.W(1 + NUM_CH*SEL_W + NUM_CH)) u_s1 (
        .clk (clk),
        .rst (rst),
        .d   ({in_valid, sel, src_en & {NUM_CH{in_valid}}}),
        .q   ({v1, sel1, en1})
    );

    xbar_route #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_route (
        .sel      (sel1),
        .src_en   (en1),
        .q        (q),
        .lane     (r_lane),
        .lane_hit (r_hit),
        .conflict (r_cf)
    );

    assign evt = r_cf & v1;

    if (PIPE_OUT != 0) begin : g_reg
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                lane      <= '0;
                lane_hit  <= '0;
                out_valid <= 1'b0;
                conflict  <= 1'b0;
            end else begin
                lane      <= r_lane;
                lane_hit  <= r_hit;
                out_valid <= v1;
                conflict  <= evt;
            end
    end else begin : g_comb
        assign lane      = r_lane;
        assign lane_hit  = r_hit;
        assign out_valid = v1;
        assign conflict  = evt;
    end

    // a clear and a fresh conflict in the same cycle leave exactly one counted
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else begin
            conflict_sticky <= (conflict_sticky & ~clr_err) | evt;
            if (clr_err)                   conflict_cnt <= CNT_W'(evt);
            else if (evt && ~&conflict_cnt) conflict_cnt <= conflict_cnt + 1'b1;
        end
endmodule

// File: doc/bf_in_xbar.md
Name: bf_in_xbar

Overview:
- Parametrised bank-to-butterfly input crossbar for the NTT datapath.
- Routes NUM_CH memory-bank read words to NUM_CH butterfly operand lanes, in lane order u0,v0,u1,v1,...
- Per-source select and enable are registered to align with the one-cycle bank read latency; data is routed with an optional output register.
- Adds valid tracking, lane-hit reporting and routing-conflict detection with sticky flag and saturating counter.

Parameters:
- DATA_W, 14, coefficient width.
- NUM_CH, 4, number of sources and lanes; power of two, 2..16.
- SEL_W, clog2(NUM_CH), localparam; per-source select width.
- PIPE_OUT, 1, 1 = registered outputs, 0 = combinational outputs.
- CNT_W, 16, conflict counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  a bank read was issued this cycle; sel and src_en are qualified by it.
- sel  in  NUM_CH*SEL_W  destination lane for each source; source i occupies bits [i*SEL_W +: SEL_W].
- src_en  in  NUM_CH  per-source drive enable.
- q  in  NUM_CH*DATA_W  bank read data; valid one cycle after the in_valid cycle.
- clr_err  in  1  synchronous clear of conflict_sticky and conflict_cnt.
- lane  out  NUM_CH*DATA_W  routed operands; lane j occupies bits [j*DATA_W +: DATA_W].
- lane_hit  out  NUM_CH  lane j was driven by an enabled source.
- out_valid  out  1  lane and lane_hit are valid.
- conflict  out  1  one-cycle pulse, aligned with out_valid, when the routed word had a collision.
- conflict_sticky  out  1  set by any conflict; held until clr_err.
- conflict_cnt  out  CNT_W  count of conflicted words; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous): all registers clear. lane=0, lane_hit=0, out_valid=0, conflict=0, conflict_sticky=0, conflict_cnt=0.
- Stage S1 (edge t): register in_valid, sel and src_en. If in_valid=0, the registered src_en becomes 0, so a stale select never drives a lane.
- Routing (cycle t+1, combinational on the S1 registers and q):
  - lane[j] = q[i] for the highest-index enabled source i with sel[i]=j.
  - Highest index wins on collision; this priority is fixed.
  - A lane with no enabled source = 0, lane_hit[j]=0.
- Conflict condition: two or more enabled sources select the same lane. This is evaluated only when the S1 valid is 1.
- Latency from in_valid to out_valid:
  - PIPE_OUT=1: 2 cycles. lane, lane_hit, out_valid and conflict are registered at edge t+1 and visible in cycle t+2.
  - PIPE_OUT=0: 1 cycle. Outputs are visible in cycle t+1, directly from routing logic.
- No backpressure. One word is accepted per cycle and back-to-back valids stream at full rate.
- When out_valid=0: lane=0, lane_hit=0, conflict=0.
- Error bookkeeping (registered, same edge the conflict pulse is produced):
  - conflict_sticky is set on a conflict.
  - conflict_cnt increments on a conflict unless it is all-ones.
  - clr_err alone: sticky=0, cnt=0.
  - clr_err together with a new conflict: sticky=1, cnt=1 (the clear applies first, then the new event counts).
- Reset mid-stream: in-flight words are discarded and there is no spurious out_valid after release. The first output is 1 (PIPE_OUT=0) or 2 (PIPE_OUT=1) cycles after the first post-reset in_valid.
- sel values are always in range for power-of-two NUM_CH. No wrap-around handling is needed.

Decomposition:
- Shared package ntt_pkg:
  - DATA_W default, CNT_W default.
  - clog2 function.
  - Lane index constants (LANE_U0=0, LANE_V0=1, LANE_U1=2, LANE_V1=3) for NUM_CH=4 users.
- Sub-module xbar_route: purely combinational priority router plus conflict detector. Inputs sel, src_en, q; outputs lane, lane_hit, conflict. It is reused later by the butterfly-output network.
- The existing DFF cell is reused for the S1 select/enable registers.

Test Plan:
- Identity, NUM_CH=4, PIPE_OUT=1:
  - Stimulus: sel={3,2,1,0}, src_en=4'hF, in_valid at cycle 0; q={0x0003,0x0002,0x0001,0x0000} at cycle 1.
  - Required: cycle 2 lane={3,2,1,0}, lane_hit=4'hF, out_valid=1, conflict=0.
- Permutation:
  - Stimulus: sel (src3..0)={0,1,2,3}, q={0x0AAA,0x0BBB,0x0CCC,0x0DDD}.
  - Required: lane(3..0)={0x0DDD,0x0CCC,0x0BBB,0x0AAA}, conflict=0.
- Collision:
  - Stimulus: all sources sel=1, q=src index+0x100.
  - Required: lane1=0x103, lane_hit=4'b0010, other lanes 0, conflict pulse, conflict_sticky=1, conflict_cnt=1.
- Masking plus stale select:
  - Stimulus: src_en=4'b0101 with identity sel, then an in_valid=0 cycle.
  - Required: lane_hit=4'b0101, lanes 1 and 3 = 0; next cycle out_valid=0, all lanes 0.
- Counter:
  - Stimulus: preload with CNT_W=4 and 16 conflicted words; then clr_err together with a 17th conflict.
  - Required: cnt stays 4'hF after the 16th word; after the clr_err cycle cnt=1, sticky=1.
- Reset and streaming:
  - Stimulus: back-to-back valids; assert rst low mid-stream for 1 cycle; repeat the stream with PIPE_OUT=0.
  - Required: outputs zero immediately on reset, no out_valid until 2 (PIPE_OUT=1) / 1 (PIPE_OUT=0) cycles after the first post-reset in_valid.
